corr_sweep_sched: RTL and testbench

- Scheduler for the 8-bit x 128-word RAM-based shift register in the correlator datapath.
- Accepts the ADC sample strobe and paces writes so that no sample lands during a sweep.
- Drives the accumulator bank with a lag index and accumulate/clear enables, counts integration frames and reports overruns.
- Sits between the sample front-end and the shift RAM plus lag accumulators.

---
 rtl/corr_pkg.sv | 9 +
 rtl/corr_lag_counter.sv | 19 +
 rtl/corr_sweep_sched.sv | 125 ++++++++++++
 tb/tb_corr_sweep_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/corr_pkg.sv
// corr_pkg: shared constants and state encoding for the correlator sweep scheduler
package corr_pkg;
  localparam int DW = 8;
  localparam int DEPTH = 128;
  localparam int AW = 7;
  localparam int SWEEP_LAT = 2;
  localparam logic [7:0] OVR_MAX = 8'd255;
  typedef enum logic [2:0] {IDLE, WAIT, LAT, SWEEP, FRAME_END} state_t;
endpackage

// File: rtl/corr_lag_counter.sv
// corr_lag_counter: loadable down-counter shared by the latency wait and the lag sweep
module corr_lag_counter
  import corr_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] cnt,
  output logic          tc
);
  assign tc = cnt == '0;
  // load wins over decrement; the count parks at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !tc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/corr_sweep_sched.sv
// corr_sweep_sched: paces sample writes into the shift RAM around lag sweeps and drives
// the accumulator bank. Optional macro CORR_WARMUP_SKIP_EN suppresses accumulation until
// the RAM has been filled with DEPTH fresh samples and adds the warm output.
module corr_sweep_sched
  import corr_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic [15:0]   cfg_n_int,
  input  logic          sample_vld,
  input  logic [DW-1:0] sample_in,
  output logic [DW-1:0] sram_din,
  output logic          sram_sin,
  output logic          acc_en,
  output logic          acc_clr,
  output logic [AW-1:0] lag_idx,
  output logic          frame_done,
  output logic          busy,
`ifdef CORR_WARMUP_SKIP_EN
  output logic          warm,
`endif
  output logic [7:0]    ovr_cnt
);
  state_t state;
  logic [15:0] sweep_cnt, n_lat, sweep_nxt;
  logic first, live, accept, tc, cnt_load;
  logic [AW-1:0] cnt;
  assign accept = state == WAIT && cfg_en && sample_vld;
  assign cnt_load = accept || (state == LAT && tc);
  assign sweep_nxt = sweep_cnt + 16'd1;
  corr_lag_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (state == LAT || state == SWEEP),
    .load_val (state == WAIT ? AW'(SWEEP_LAT - 1) : AW'(DEPTH - 1)),
    .cnt      (cnt),
    .tc       (tc)
  );
`ifdef CORR_WARMUP_SKIP_EN
  logic [AW-1:0] warm_cnt;
  assign live = warm;
  // count warmup sweeps since enable; warm once DEPTH fresh samples are in the RAM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      warm_cnt <= '0;
      warm <= 1'b0;
    end else if (state == IDLE && cfg_en) begin
      warm_cnt <= '0;
      warm <= 1'b0;
    end else if (state == SWEEP && tc && !warm) begin
      warm_cnt <= warm_cnt + 1'b1;
      warm <= warm_cnt == AW'(DEPTH - 1);
    end
`else
  assign live = 1'b1;
`endif
  // scheduler FSM with all outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sweep_cnt <= '0;
      n_lat <= '0;
      first <= 1'b0;
      sram_din <= '0;
      sram_sin <= 1'b0;
      acc_en <= 1'b0;
      acc_clr <= 1'b0;
      lag_idx <= '0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      ovr_cnt <= '0;
    end else begin
      sram_sin <= 1'b0;
      frame_done <= 1'b0;
      if (sample_vld && state inside {LAT, SWEEP, FRAME_END} && ovr_cnt != OVR_MAX) ovr_cnt <= ovr_cnt + 8'd1;
      case (state)
        IDLE: if (cfg_en) begin
          state <= WAIT;
          ovr_cnt <= '0;
          sweep_cnt <= '0;
          first <= 1'b1;
        end
        WAIT: if (!cfg_en) state <= IDLE;
        else if (sample_vld) begin
          state <= LAT;
          busy <= 1'b1;
          sram_sin <= 1'b1;
          sram_din <= sample_in;
          if (first) n_lat <= cfg_n_int == '0 ? 16'd1 : cfg_n_int;
        end
        LAT: if (tc) begin
          state <= SWEEP;
          acc_en <= live;
          acc_clr <= live && first;
          lag_idx <= AW'(DEPTH - 1);
        end
        SWEEP: if (!tc) lag_idx <= lag_idx - 1'b1;
        else begin
          acc_en <= 1'b0;
          acc_clr <= 1'b0;
          lag_idx <= '0;
          if (!live) begin
            state <= cfg_en ? WAIT : IDLE;
            busy <= 1'b0;
          end else if (sweep_nxt == n_lat) begin
            state <= FRAME_END;
            frame_done <= 1'b1;
            sweep_cnt <= '0;
            first <= 1'b1;
          end else begin
            state <= cfg_en ? WAIT : IDLE;
            busy <= 1'b0;
            sweep_cnt <= sweep_nxt;
            first <= 1'b0;
          end
        end
        default: begin
          state <= cfg_en ? WAIT : IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_corr_sweep_sched.sv
// tb_corr_sweep_sched: directed checks of sweep timing, integration, overrun, disable and reset
module tb_corr_sweep_sched;
  logic clk = 1'b0, rst_n = 1'b0, cfg_en = 1'b0, sample_vld = 1'b0;
  logic [15:0] cfg_n_int = 16'd1;
  logic [7:0] sample_in = 8'd0;
  logic [7:0] sram_din, ovr_cnt;
  logic sram_sin, acc_en, acc_clr, frame_done, busy;
  logic [6:0] lag_idx;
  int checks = 0, passed = 0;

  corr_sweep_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_n_int(cfg_n_int),
    .sample_vld(sample_vld), .sample_in(sample_in), .sram_din(sram_din),
    .sram_sin(sram_sin), .acc_en(acc_en), .acc_clr(acc_clr), .lag_idx(lag_idx),
    .frame_done(frame_done), .busy(busy), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input logic [7:0] d);
    sample_vld = 1'b1;
    sample_in = d;
    step(1);
    sample_vld = 1'b0;
  endtask

  task automatic test_reset;
    step(3);
    checks++;
    if ({sram_din, sram_sin, acc_en, acc_clr, lag_idx, frame_done, busy, ovr_cnt} !== 29'd0)
      $display("FAIL reset_outputs got %h want 0", {sram_din, sram_sin, acc_en, acc_clr, lag_idx, frame_done, busy, ovr_cnt});
    else passed++;
    rst_n = 1'b1;
    step(2);
    checks++;
    if ({sram_sin, acc_en, busy} !== 3'b000) $display("FAIL idle_after_reset got %b want 000", {sram_sin, acc_en, busy});
    else passed++;
  endtask

  task automatic test_basic;
    int bad = 0;
    cfg_n_int = 16'd1;
    cfg_en = 1'b1;
    step(1);
    accept(8'h5A);
    checks++;
    if ({sram_sin, sram_din, busy, acc_en} !== {1'b1, 8'h5A, 1'b1, 1'b0})
      $display("FAIL basic_write got sin=%b din=%h busy=%b acc=%b want 1 5a 1 0", sram_sin, sram_din, busy, acc_en);
    else passed++;
    step(1);
    checks++;
    if ({sram_sin, acc_en} !== 2'b00) $display("FAIL basic_lat got sin/acc=%b want 00", {sram_sin, acc_en});
    else passed++;
    step(1);
    checks++;
    if ({acc_en, acc_clr, lag_idx} !== {2'b11, 7'd127}) $display("FAIL basic_first_lag got en/clr=%b lag=%0d want 11 127", {acc_en, acc_clr}, lag_idx);
    else passed++;
    for (int j = 1; j < 128; j++) begin
      step(1);
      if (acc_en !== 1'b1 || acc_clr !== 1'b1 || lag_idx !== 7'(127 - j) || frame_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL basic_sweep_window got %0d bad cycles want 0", bad);
    else passed++;
    step(1);
    checks++;
    if ({frame_done, acc_en, lag_idx, busy} !== {1'b1, 1'b0, 7'd0, 1'b1})
      $display("FAIL basic_frame_done got fd=%b acc=%b lag=%0d busy=%b want 1 0 0 1", frame_done, acc_en, lag_idx, busy);
    else passed++;
    step(1);
    checks++;
    if ({frame_done, busy} !== 2'b00) $display("FAIL basic_back_to_wait got fd/busy=%b want 00", {frame_done, busy});
    else passed++;
  endtask

  task automatic test_integration;
    int fd_early = 0;
    logic exp_fd, exp_clr;
    cfg_n_int = 16'd3;
    for (int k = 0; k < 4; k++) begin
      accept(8'(k + 1));
      if (k == 0) cfg_n_int = 16'd1;
      step(2);
      exp_clr = (k == 0 || k == 3);
      checks++;
      if (acc_clr !== exp_clr || acc_en !== 1'b1) $display("FAIL integ_clr_sweep%0d got clr=%b en=%b want %b 1", k + 1, acc_clr, acc_en, exp_clr);
      else passed++;
      for (int j = 0; j < 127; j++) begin
        step(1);
        if (frame_done !== 1'b0) fd_early++;
      end
      step(1);
      exp_fd = (k == 2 || k == 3);
      checks++;
      if (frame_done !== exp_fd) $display("FAIL integ_frame_done_sweep%0d got %b want %b", k + 1, frame_done, exp_fd);
      else passed++;
      if (exp_fd) step(1);
    end
    checks++;
    if (fd_early != 0) $display("FAIL integ_stray_frame_done got %0d want 0", fd_early);
    else passed++;
  endtask

  task automatic test_overrun;
    int sins = 0;
    int cur = 1;
    accept(8'hA5);
    if (sram_sin === 1'b1) sins++;
    while (cur < 131) begin
      if (cur == 40 || cur == 130) sample_vld = 1'b1;
      step(1);
      sample_vld = 1'b0;
      cur++;
      if (sram_sin === 1'b1) sins++;
    end
    checks++;
    if (ovr_cnt !== 8'd2) $display("FAIL ovr_count got %0d want 2", ovr_cnt);
    else passed++;
    checks++;
    if (sins != 1) $display("FAIL ovr_single_write got %0d want 1", sins);
    else passed++;
    step(1);
    checks++;
    if ({busy, sram_sin} !== 2'b00) $display("FAIL ovr_edge_not_accepted got busy/sin=%b want 00", {busy, sram_sin});
    else passed++;
    sample_vld = 1'b1;
    step(400);
    sample_vld = 1'b0;
    for (int i = 0; i < 300 && busy !== 1'b0; i++) step(1);
    checks++;
    if (busy !== 1'b0) $display("FAIL ovr_drain_timeout got busy=%b want 0", busy);
    else passed++;
    checks++;
    if (ovr_cnt !== 8'd255) $display("FAIL ovr_saturate got %0d want 255", ovr_cnt);
    else passed++;
  endtask

  task automatic test_disable;
    int fds = 0;
    cfg_en = 1'b0;
    step(2);
    cfg_n_int = 16'd2;
    cfg_en = 1'b1;
    step(1);
    checks++;
    if (ovr_cnt !== 8'd0) $display("FAIL dis_reenable_clears_ovr got %0d want 0", ovr_cnt);
    else passed++;
    accept(8'h11);
    step(49);
    cfg_en = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (frame_done !== 1'b0) fds++;
    end
    checks++;
    if ({acc_en, lag_idx} !== {1'b1, 7'd0}) $display("FAIL dis_sweep_completes got en=%b lag=%0d want 1 0", acc_en, lag_idx);
    else passed++;
    step(1);
    if (frame_done !== 1'b0) fds++;
    checks++;
    if ({acc_en, busy, fds} !== {2'b00, 32'd0}) $display("FAIL dis_to_idle got en=%b busy=%b fd_count=%0d want 0 0 0", acc_en, busy, fds);
    else passed++;
    accept(8'h22);
    step(1);
    checks++;
    if ({sram_sin, busy, ovr_cnt} !== 10'd0) $display("FAIL dis_idle_ignores_vld got sin=%b busy=%b ovr=%0d want 0 0 0", sram_sin, busy, ovr_cnt);
    else passed++;
  endtask

  task automatic test_async_reset;
    int bad = 0;
    cfg_n_int = 16'd1;
    cfg_en = 1'b1;
    step(1);
    accept(8'h77);
    step(59);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_din, sram_sin, acc_en, acc_clr, lag_idx, frame_done, busy, ovr_cnt} !== 29'd0)
      $display("FAIL areset_immediate got %h want 0", {sram_din, sram_sin, acc_en, acc_clr, lag_idx, frame_done, busy, ovr_cnt});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if ({acc_en, busy} !== 2'b00) bad++;
    end
    rst_n = 1'b1;
    cfg_n_int = 16'd0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if ({acc_en, busy} !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL areset_quiet got %0d bad cycles want 0", bad);
    else passed++;
    accept(8'h3C);
    checks++;
    if ({sram_sin, sram_din} !== {1'b1, 8'h3C}) $display("FAIL areset_reaccept got sin=%b din=%h want 1 3c", sram_sin, sram_din);
    else passed++;
    step(2);
    checks++;
    if ({acc_en, acc_clr, lag_idx} !== {2'b11, 7'd127}) $display("FAIL areset_sweep got en/clr=%b lag=%0d want 11 127", {acc_en, acc_clr}, lag_idx);
    else passed++;
    step(128);
    checks++;
    if (frame_done !== 1'b1) $display("FAIL nint_zero_as_one got fd=%b want 1", frame_done);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_integration;
    test_overrun;
    test_disable;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
